// File: rtl/piece_queue.sv
// piece_queue: 7-bag tetromino picker with rejection sampling and a
// bounded forced pick, feeding a small shift-register preview FIFO.
module piece_queue #(
    parameter int DEPTH     = 3,
    parameter int MAX_TRIES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         lfsr_in,
    input  logic               pop,
    output logic               head_valid,
    output logic [2:0]         head_id,
    output logic [3*DEPTH-1:0] q_ids,
    output logic [2:0]         q_count,
    output logic [6:0]         bag_mask
);

    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
    localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);
    localparam logic [2:0] EMPTY_ID = 3'd7;
    localparam logic [6:0] FULL_BAG = 7'h7F;

    logic [2:0] slots_q [DEPTH];
    logic [2:0] slots_d [DEPTH];
    logic [2:0] count_q;
    logic [2:0] count_d;
    logic [6:0] mask_q;
    logic [6:0] mask_d;
    logic [3:0] tries_q;
    logic [3:0] tries_d;

    logic       do_pop;
    logic       push_en;
    logic       accept;
    logic       forced;
    logic       do_push;
    logic [2:0] cand;
    logic [2:0] free_id;
    logic [2:0] push_id;
    logic [2:0] push_idx;
    logic [7:0] used;
    logic [6:0] mask_set;

    // Only the low three bits of the randomizer byte select a piece.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr_in[7:3];

    // Draw qualification: a slot must be free after any pop this cycle.
    always_comb begin
        do_pop  = pop && (count_q != 3'd0);
        push_en = (count_q < DEPTH_C) || do_pop;
        cand    = lfsr_in[2:0];
        // Code 7 is never a piece, so it is treated as permanently used.
        used    = {1'b1, mask_q};
        accept  = !used[cand];
        forced  = !accept && (tries_q == LAST_TRY);
        do_push = push_en && (accept || forced);
    end

    // Lowest-index piece not yet issued from the current bag.
    always_comb begin
        free_id = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (!mask_q[i]) begin
                free_id = 3'(i);
            end
        end
    end

    // Chosen ID, its landing slot, and the bag mask after issuing it.
    always_comb begin
        push_id  = accept ? cand : free_id;
        push_idx = count_q - {2'b00, do_pop};
        mask_set = mask_q | (7'd1 << push_id);
        mask_d   = mask_q;
        if (do_push) begin
            // A completed bag is recycled at once, never held at all-ones.
            mask_d = (mask_set == FULL_BAG) ? 7'd0 : mask_set;
        end
    end

    // Attempt counter: cleared on any push, advanced on each rejected draw.
    always_comb begin
        tries_d = tries_q;
        if (push_en) begin
            if (accept || forced) begin
                tries_d = 4'd0;
            end else begin
                tries_d = tries_q + 4'd1;
            end
        end
    end

    // Queue shift on pop, then the new ID written behind the last entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slots_d[i] = slots_q[i];
        end
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                slots_d[i] = slots_q[i+1];
            end
            slots_d[DEPTH-1] = EMPTY_ID;
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == push_idx) begin
                    slots_d[i] = push_id;
                end
            end
        end
        count_d = count_q - {2'b00, do_pop} + {2'b00, do_push};
    end

    // State registers; reset discards any partially drawn bag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= EMPTY_ID;
            end
            count_q <= 3'd0;
            mask_q  <= 7'd0;
            tries_q <= 4'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
            count_q <= count_d;
            mask_q  <= mask_d;
            tries_q <= tries_d;
        end
    end

    // Outputs are direct views of registered state.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_ids[3*i +: 3] = slots_q[i];
        end
        head_id    = slots_q[0];
        head_valid = (count_q != 3'd0);
        q_count    = count_q;
        bag_mask   = mask_q;
    end

endmodule

// File: tb/tb_piece_queue.sv
// tb_piece_queue: vector table, directed corner sequences and a
// randomized phase checked against a queue-based reference model.
module tb_piece_queue;

    localparam int DEPTH = 3;
    localparam int MT    = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] lfsr_in = 8'h00;
    logic       pop = 1'b0;
    logic       head_valid;
    logic [2:0] head_id;
    logic [8:0] q_ids;
    logic [2:0] q_count;
    logic [6:0] bag_mask;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lfsr;
        int pop;
        int acc;
        int cnt;
        int head;
        int mask;
    } vec_t;

    vec_t vt[10];
    int   sb[$];
    int   mq[$];
    int   mmask;
    int   mtries;

    piece_queue #(.DEPTH(DEPTH), .MAX_TRIES(MT)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lfsr_in(lfsr_in),
        .pop(pop),
        .head_valid(head_valid),
        .head_id(head_id),
        .q_ids(q_ids),
        .q_count(q_count),
        .bag_mask(bag_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int qv(input int s2, input int s1, input int s0);
        return (s2 << 6) | (s1 << 3) | s0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: advance expected state by one clock edge.
    task automatic model_step(input int l, input int p);
        int c;
        int take;
        bit dp;
        bit pe;
        c    = l & 7;
        take = -1;
        dp   = (p != 0) && (mq.size() > 0);
        pe   = (mq.size() < DEPTH) || dp;
        if (dp) void'(mq.pop_front());
        if (pe) begin
            if (c != 7 && !mmask[c]) begin
                take = c;
            end else if (mtries == MT - 1) begin
                for (int i = 6; i >= 0; i--)
                    if (!mmask[i]) take = i;
            end else begin
                mtries++;
            end
            if (take >= 0) begin
                mq.push_back(take);
                mmask = mmask | (1 << take);
                if (mmask == 'h7F) mmask = 0;
                mtries = 0;
            end
        end
    endtask

    function automatic int model_qids();
        int v;
        v = 0;
        for (int i = 0; i < DEPTH; i++)
            v = v | (((i < mq.size()) ? mq[i] : 7) << (3 * i));
        return v;
    endfunction

    initial begin
        int l;
        int p;
        int e;

        vt[0] = '{8'h00, 0, 1, 1, 0, 'h01};
        vt[1] = '{8'h01, 1, 1, 1, 1, 'h03};
        vt[2] = '{8'h02, 1, 1, 1, 2, 'h07};
        vt[3] = '{8'h03, 1, 1, 1, 3, 'h0F};
        vt[4] = '{8'h04, 1, 1, 1, 4, 'h1F};
        vt[5] = '{8'h05, 1, 1, 1, 5, 'h3F};
        vt[6] = '{8'h06, 1, 1, 1, 6, 'h00};
        vt[7] = '{8'h08, 1, 1, 1, 0, 'h01};
        vt[8] = '{8'h00, 1, 0, 0, 7, 'h01};
        vt[9] = '{8'hFF, 1, 0, 0, 7, 'h01};

        // Reset state with no clock edge required.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", q_count, 0);
        chk("rst_head", head_id, 7);
        chk("rst_valid", head_valid, 0);
        chk("rst_mask", bag_mask, 0);
        chk("rst_qids", q_ids, qv(7, 7, 7));
        @(negedge clk);
        lfsr_in = 8'h02;
        rst_n = 1'b1;

        // Repeated candidate forces picks.
        for (e = 1; e <= 20; e++) begin
            tick();
            if (e == 1) begin
                chk("rep_e1_qids", q_ids, qv(7, 7, 2));
                chk("rep_e1_count", q_count, 1);
            end
            if (e == 8) chk("rep_e8_count", q_count, 1);
            if (e == 9) chk("rep_e9_qids", q_ids, qv(7, 0, 2));
            if (e == 17) begin
                chk("rep_e17_qids", q_ids, qv(1, 0, 2));
                chk("rep_e17_count", q_count, 3);
                chk("rep_e17_mask", bag_mask, 'h07);
            end
            if (e == 20) chk("rep_e20_count", q_count, 3);
        end

        // Invalid candidate code 7.
        lfsr_in = 8'hFF;
        do_reset();
        for (e = 1; e <= 16; e++) begin
            tick();
            if (e <= 7) chk("inv_nopush", q_count, 0);
            if (e == 8) begin
                chk("inv_e8_head", head_id, 0);
                chk("inv_e8_count", q_count, 1);
            end
            if (e == 15) chk("inv_e15_count", q_count, 1);
            if (e == 16) chk("inv_e16_qids", q_ids, qv(7, 1, 0));
        end

        // Bag rollover from the vector table, pops scored in FIFO order.
        do_reset();
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            lfsr_in = 8'(vt[i].lfsr);
            pop = vt[i].pop[0];
            if (vt[i].acc != 0) sb.push_back(vt[i].lfsr & 7);
            if (pop && head_valid) begin
                if (sb.size() == 0) begin
                    chk("pop_sb_empty", 1, 0);
                end else begin
                    chk("pop_order", head_id, sb.pop_front());
                end
            end
            tick();
            chk("vec_count", q_count, vt[i].cnt);
            chk("vec_head", head_id, vt[i].head);
            chk("vec_mask", bag_mask, vt[i].mask);
        end
        chk("vec_sb_drained", sb.size(), 0);
        pop = 1'b0;

        // Full queue: pop plus push, then no draw while full.
        do_reset();
        lfsr_in = 8'h00; tick();
        lfsr_in = 8'h01; tick();
        lfsr_in = 8'h02; tick();
        chk("full_qids", q_ids, qv(2, 1, 0));
        chk("full_count", q_count, 3);
        lfsr_in = 8'h05; pop = 1'b1; tick();
        chk("full_pp_qids", q_ids, qv(5, 2, 1));
        chk("full_pp_count", q_count, 3);
        chk("full_pp_mask", bag_mask, 'h27);
        lfsr_in = 8'h03; pop = 1'b0; tick();
        chk("full_hold_qids", q_ids, qv(5, 2, 1));
        chk("full_hold_mask", bag_mask, 'h27);
        lfsr_in = 8'hFF; pop = 1'b1;
        tick(); chk("drain_c2", q_count, 2);
        tick(); chk("drain_c1", q_count, 1);
        tick(); chk("drain_c0", q_count, 0);
        tick();
        chk("empty_pop_count", q_count, 0);
        chk("empty_pop_head", head_id, 7);
        chk("empty_pop_valid", head_valid, 0);
        pop = 1'b0;

        // Asynchronous reset between edges with two entries queued.
        do_reset();
        lfsr_in = 8'h03; tick();
        lfsr_in = 8'h04; tick();
        chk("ar_pre_count", q_count, 2);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_valid", head_valid, 0);
        chk("ar_count", q_count, 0);
        chk("ar_mask", bag_mask, 0);
        chk("ar_head", head_id, 7);
        lfsr_in = 8'h03;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_refill_count", q_count, 1);
        chk("ar_refill_head", head_id, 3);
        chk("ar_refill_mask", bag_mask, 'h08);

        // Randomized traffic against the reference model.
        do_reset();
        mq.delete();
        mmask = 0;
        mtries = 0;
        for (int n = 0; n < 400; n++) begin
            l = int'($urandom_range(255, 0));
            p = ($urandom_range(9, 0) < 4) ? 1 : 0;
            lfsr_in = 8'(l);
            pop = p[0];
            model_step(l, p);
            tick();
            chk("rnd_count", q_count, mq.size());
            chk("rnd_qids", q_ids, model_qids());
            chk("rnd_mask", bag_mask, mmask);
        end
        pop = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piece_queue.md
# piece_queue

Tetromino picker and preview queue for the Tetris datapath. It consumes the free-running 8-bit pseudo-random byte from the randomizer. It converts that byte into a fair 7-bag sequence of piece IDs by rejection sampling against a per-bag used mask, with a bounded-latency forced pick. Accepted IDs are held in a small shift-register FIFO, which the game controller pops when it spawns a piece and which the preview display reads.

## Interface
- `DEPTH`, default 3: preview queue depth; legal range 1..4.
- `MAX_TRIES`, default 8: draw attempts per piece before a forced pick; legal range 2..15.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset. One clock domain; `rst_n` is asynchronous and active-low.
- `lfsr_in` in 8: randomizer byte. Only `lfsr_in[2:0]` is used. It changes every cycle.
- `pop` in 1: consume the head entry. Ignored when `head_valid` = 0.
- `head_valid` out 1: queue is not empty.
- `head_id` out 3: head piece ID. Encoding: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L. Reads 7 when empty.
- `q_ids` out 3*DEPTH: queue slots. Slot 0 (bits [2:0]) is the head. Unoccupied slots read 3'd7.
- `q_count` out 3: number of occupied slots, 0..DEPTH.
- `bag_mask` out 7: bit n set means piece n has already been issued from the current bag.

## Operation
- **Reset state** (asynchronous, immediate, no clock required):
  - `q_count` = 0.
  - All slots = 7, so `head_id` = 7.
  - `head_valid` = 0.
  - `bag_mask` = 0.
  - Internal `tries` = 0.
- **Push enable:** `push_en` = (`q_count` < DEPTH) or (`pop` and `head_valid`). When `push_en` = 0, no draw happens and `tries` holds.
- **Candidate:** `c` = `lfsr_in[2:0]`. A candidate is accepted when `c` != 7 and `bag_mask[c]` = 0.
- **Per draw cycle:**
  - On accept: push `c`, set `bag_mask[c]`, clear `tries`.
  - On reject with `tries` < MAX_TRIES-1: increment `tries`.
  - On reject with `tries` = MAX_TRIES-1 (forced pick): push the lowest-index unused piece from `bag_mask`, set its bit, clear `tries`.
- **Bag rollover:** if a push makes `bag_mask` = 7'h7F, the mask is written as 0 in the same cycle. It is never observed as 7'h7F.
- **Pop:** slot i takes slot i+1, the top slot becomes 7, and `q_count` decrements.
- **Pop and push in the same cycle:** the new ID lands at index `q_count`-1 (after the shift). `q_count` is unchanged.
- **Pop on empty:** no effect on queue state. A draw still proceeds, because `q_count` < DEPTH.
- **Queue order:** strictly FIFO. IDs never reorder or duplicate within a bag.

## Timing
- All outputs are registered and update on the rising edge of `clk`.
- Push latency: an accepted candidate sampled at edge k is visible in `q_ids` / `q_count` after edge k.
- Best case: DEPTH pieces are queued DEPTH edges after reset release, if every candidate is accepted.
- Worst case: one piece per MAX_TRIES edges, so the queue is full within DEPTH*MAX_TRIES edges of reset or of becoming empty.
- `head_valid` / `head_id` after a pop reflect the new head one edge later. There is no combinational path from `pop` to any output.
- Reset assertion mid-draw abandons the draw. The partially filled bag is discarded, and `bag_mask` = 0 after release.

## Test plan
- **Repeated candidate forces picks.** Reset, DEPTH=3, MAX_TRIES=8, hold `lfsr_in`=8'h02, no pop.
  - After edge 1: `q_ids`={7,7,2}, `q_count`=1.
  - After edge 9: piece 0 is forced.
  - After edge 17: piece 1 is forced, `q_ids`={1,0,2}, `q_count`=3, `bag_mask`=7'h07.
  - `q_count` then stays 3.
- **Invalid candidate.** Hold `lfsr_in`=8'hFF (`c`=7).
  - No push for edges 1-7.
  - Edge 8 forces piece 0: `head_id`=0, `tries`=0.
- **Bag rollover.** Feed `c`=0,1,...,6 on consecutive edges with `pop` asserted whenever `head_valid`=1.
  - Popped IDs are 0..6 in order.
  - `bag_mask` reads 0 after the 7th accept.
  - Next `c`=0 is accepted immediately.
- **Full-queue behaviour.** Fill the queue to 3, then assert `pop` for one cycle with `c`=5 unused.
  - The head shifts out and 5 lands in slot 2.
  - `q_count` stays 3.
  - A pop while empty leaves `q_count`=0 and `head_id`=7.
- **Asynchronous reset mid-fill.** Drive `rst_n` low between clock edges with `q_count`=2.
  - `head_valid`=0, `q_count`=0, `bag_mask`=0 before the next edge.
  - After release, the refill restarts at edge 1.
